// File: rtl/mem_interface_if.sv
// RAM-side bus of mem_interface.
// Build option: none. This file only declares the bus signals.
//   mem_addr  : RAM word address (ADDR_W bits)
//   mem_wdata : RAM write data
//   mem_re    : RAM read strobe
//   mem_we    : RAM write strobe
//   mem_rdata : RAM read data, valid while mem_ready=1
//   mem_ready : RAM completion strobe
// The master modport is the controller side. The slave modport is the RAM side.
interface mem_interface_if #(
  parameter int unsigned ADDR_W = 9
);
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_re;
  logic              mem_we;
  logic [31:0]       mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_addr, mem_wdata, mem_re, mem_we,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_re, mem_we,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mem_interface.sv
// mem_interface: connects the datapath MAR/MDR to a single-port RAM.
// The datapath issues one-cycle read/write requests. The block holds the RAM
// strobes until mem_ready. It then pulses done and has a one-entry pending
// buffer for a request that arrives while a transaction is in progress.
//
// Ports:
//   clk, clr              : clock and synchronous active-high reset
//   mar_data, mdr_wdata   : address (low ADDR_W bits used) and write data
//   read, write           : one-cycle requests. When both are set, write wins.
//   rd_data               : registered read result
//   done, err             : completion pulse. err marks an aborted transaction.
//   busy                  : transaction active or pending
//   overflow              : sticky. A request was dropped.
//   mem                   : RAM bus (mem_interface_if.master)
//
// Build option MEM_TIMEOUT_EN:
//   When defined, ACCESS aborts after TIMEOUT cycles without mem_ready.
//   When undefined, ACCESS waits indefinitely and err is tied to 0.
module mem_interface #(
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic [31:0]          mar_data,
  input  logic [31:0]          mdr_wdata,
  input  logic                 read,
  input  logic                 write,
  output logic [31:0]          rd_data,
  output logic                 done,
  output logic                 err,
  output logic                 busy,
  output logic                 overflow,
  mem_interface_if.master      mem
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state_q, state_d;
  logic [31:0]       rd_data_q, rd_data_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              overflow_q, overflow_d;
  logic              re_q, re_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              pnd_full_q, pnd_full_d;
  logic              pnd_we_q, pnd_we_d;
  logic [ADDR_W-1:0] pnd_addr_q, pnd_addr_d;
  logic [31:0]       pnd_wdata_q, pnd_wdata_d;
  logic              req;
  logic              unused_mar_hi;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  assign req           = read | write;
  assign unused_mar_hi = ^mar_data[31:ADDR_W];

  always_comb begin
    state_d     = state_q;
    rd_data_d   = rd_data_q;
    done_d      = 1'b0;
    overflow_d  = overflow_q;
    re_d        = re_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    pnd_full_d  = pnd_full_q;
    pnd_we_d    = pnd_we_q;
    pnd_addr_d  = pnd_addr_q;
    pnd_wdata_d = pnd_wdata_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (req) begin
          state_d = ACCESS;
          addr_d  = mar_data[ADDR_W-1:0];
          wdata_d = mdr_wdata;
          we_d    = write;
          re_d    = ~write;
`ifdef MEM_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ACCESS: begin
        if (req) begin
          if (pnd_full_q) begin
            overflow_d = 1'b1;
          end else begin
            pnd_full_d  = 1'b1;
            pnd_we_d    = write;
            pnd_addr_d  = mar_data[ADDR_W-1:0];
            pnd_wdata_d = mdr_wdata;
          end
        end
        if (mem.mem_ready) begin
          re_d    = 1'b0;
          we_d    = 1'b0;
          done_d  = 1'b1;
          state_d = RESP;
          if (re_q) rd_data_d = mem.mem_rdata;
        end
`ifdef MEM_TIMEOUT_EN
        // The compare against TIMEOUT-1 makes the abort happen on the
        // TIMEOUT-th cycle without mem_ready.
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          re_d    = 1'b0;
          we_d    = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      RESP: begin
        // A buffered request issues first. A new request in this cycle then
        // finds the buffer full and is dropped. If the buffer is empty, a new
        // request issues directly, so no IDLE cycle is inserted.
        if (pnd_full_q) begin
          state_d    = ACCESS;
          addr_d     = pnd_addr_q;
          wdata_d    = pnd_wdata_q;
          we_d       = pnd_we_q;
          re_d       = ~pnd_we_q;
          pnd_full_d = 1'b0;
          if (req) overflow_d = 1'b1;
        end else if (req) begin
          state_d = ACCESS;
          addr_d  = mar_data[ADDR_W-1:0];
          wdata_d = mdr_wdata;
          we_d    = write;
          re_d    = ~write;
        end else begin
          state_d = IDLE;
        end
`ifdef MEM_TIMEOUT_EN
        cnt_d = '0;
`endif
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE) || pnd_full_d;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= IDLE;
      rd_data_q   <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
      re_q        <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      pnd_full_q  <= 1'b0;
      pnd_we_q    <= 1'b0;
      pnd_addr_q  <= '0;
      pnd_wdata_q <= '0;
`ifdef MEM_TIMEOUT_EN
      cnt_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rd_data_q   <= rd_data_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      overflow_q  <= overflow_d;
      re_q        <= re_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      pnd_full_q  <= pnd_full_d;
      pnd_we_q    <= pnd_we_d;
      pnd_addr_q  <= pnd_addr_d;
      pnd_wdata_q <= pnd_wdata_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q       <= cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  assign rd_data       = rd_data_q;
  assign done          = done_q;
  assign busy          = busy_q;
  assign overflow      = overflow_q;
  assign mem.mem_re    = re_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
`ifdef MEM_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/mem_interface.md
MEM_INTERFACE -- requirements
Module: mem_interface

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, memory word-address width (512 words).
REQ-002 SHALL have parameter TIMEOUT, default 16, maximum number of ACCESS cycles waiting on mem_ready.
REQ-003 SHALL have ports:
- clk  in  1  single clock; all state updates on the rising edge.
- clr  in  1  reset, synchronous, active-high.
- mar_data  in  32  address from the datapath MAR.
- mdr_wdata  in  32  write data from the datapath MDR.
- read  in  1  one-cycle read request.
- write  in  1  one-cycle write request.
- rd_data  out  32  registered read result, loaded into the datapath MDR.
- done  out  1  one-cycle pulse when a transaction completes.
- err  out  1  one-cycle pulse with done when a transaction was aborted.
- busy  out  1  high while any transaction is active or pending.
- overflow  out  1  sticky; a request was dropped.
- mem_addr  out  ADDR_W  RAM word address.
- mem_wdata  out  32  RAM write data.
- mem_re  out  1  RAM read strobe.
- mem_we  out  1  RAM write strobe.
- mem_rdata  in  32  RAM read data; valid when mem_ready=1.
- mem_ready  in  1  RAM completion strobe.

Function
REQ-004 SHALL implement the FSM states IDLE, ACCESS and RESP; all outputs registered.
REQ-005 Request capture:
- A request (read or write) is accepted in IDLE and latches mar_data[ADDR_W-1:0], mdr_wdata and the op.
- If read and write are both high in the same cycle, write wins and the read is discarded without setting overflow.
REQ-006 IDLE -> ACCESS on an accepted request; mem_re or mem_we is asserted and mem_addr/mem_wdata are driven from the cycle after the request.
REQ-007 ACCESS behaviour:
- Strobes and address are held stable until mem_ready=1.
- On mem_ready=1: for a read, rd_data <= mem_rdata; strobes drop next cycle; go to RESP.
REQ-008 RESP SHALL last exactly one cycle with done=1.
- Then go to ACCESS if a pending request exists, else IDLE.
- Zero-wait latency: request at cycle n -> strobe at n+1 -> done at n+2.
REQ-009 A one-entry pending buffer SHALL capture a request arriving while state is ACCESS or RESP.
- A request arriving while the buffer is full is dropped and sets overflow.
- A pending request issues from RESP with no IDLE cycle.
REQ-010 busy SHALL be 1 in ACCESS and RESP, and whenever the pending buffer is full.
REQ-011 rd_data SHALL change only on a completed read and hold its value otherwise, including across writes.
REQ-012 mem_re and mem_we SHALL never be high simultaneously.
REQ-013 mar_data bits above ADDR_W SHALL be ignored.

Reset
REQ-014 On clr=1 at a clock edge, the block SHALL set:
- state IDLE, pending buffer empty, wait counter 0;
- rd_data=0, done=0, err=0, busy=0, overflow=0, mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-015 clr SHALL take priority over any request in the same cycle; a transaction in flight is abandoned without done.

Configuration
REQ-016 Macro MEM_TIMEOUT_EN:
- Defined: a counter increments each ACCESS cycle with mem_ready=0. When it reaches TIMEOUT, strobes drop, rd_data is unchanged, and RESP is entered with done=1, err=1. The counter clears on entry to ACCESS.
- Undefined: ACCESS waits indefinitely; err is tied 0.

Verification
REQ-017 Reset, then read with mar_data=0x00000005, mem_ready=1 at first strobe, mem_rdata=0x12345678 -> mem_addr=5, mem_re one cycle, done 2 cycles after the request, rd_data=0x12345678.
REQ-018 Write mar_data=0x00000203, mdr_wdata=0xCAFEF00D, mem_ready delayed 3 cycles -> mem_we held 4 cycles at mem_addr=0x003; done=1 with err=0; rd_data unchanged.
REQ-019 Read in flight, second read arrives, then a third before completion -> second issues directly from RESP; third dropped; overflow=1; two done pulses.
REQ-020 read=write=1 same cycle -> only mem_we asserted; overflow stays 0.
REQ-021 With MEM_TIMEOUT_EN defined, mem_ready held 0 -> after 16 ACCESS cycles, done=1 and err=1, strobes 0, busy 0 next cycle.
REQ-022 clr asserted during ACCESS -> next cycle: all outputs 0, state IDLE, no done pulse.
